// File: rtl/discus_pkg.sv
// Shared state encoding and snoop-mode constants for the discus program loader.
// The VERIFY state only exists when DISCUS_LOADER_VERIFY_EN is defined.
package discus_pkg;

    localparam logic SNOOP_WR = 1'b0;
    localparam logic SNOOP_RD = 1'b1;

`ifdef DISCUS_LOADER_VERIFY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        RUN    = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd3
    } state_e;
`endif

endpackage

// File: rtl/discus_csum8.sv
// 8-bit wrap-around additive checksum with synchronous clear and add enable.
module discus_csum8 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr_i,
    input  logic       add_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (clr_i) begin
            sum_q <= '0;
        end else if (add_i) begin
            sum_q <= sum_q + data_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/discus_loader.sv
// Streams a program into the discus CPU through its snoop port, holding the CPU in reset
// until the image is loaded. Optional read-back check: define DISCUS_LOADER_VERIFY_EN.
module discus_loader
    import discus_pkg::*;
#(
    parameter int MAX_LEN = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       cpu_reset,
    output logic [7:0] snoopa,
    output logic [7:0] snoopd,
    output logic       snoopp,
    output logic       snoopm,
    input  logic [7:0] snoopq,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [8:0] count
);

    localparam logic [8:0] MAX_CNT = 9'(MAX_LEN);

    state_e     state_q, state_d;
    // count_q doubles as the write address of the next accepted byte.
    logic [8:0] count_q, count_d;
    logic       stop_q, stop_d;
    logic       abort_q, abort_d;
    logic       error_q, error_d;
    logic       cpu_reset_q, cpu_reset_d;
    logic       snoopp_q, snoopp_d;
    logic [7:0] snoopa_q, snoopa_d;
    logic [7:0] snoopd_q, snoopd_d;
    logic       csum_clr;
    logic       accept;
    logic [7:0] wr_sum;

    assign in_ready = (state_q == LOAD) && !stop_q;
    assign accept   = in_valid && in_ready;

    discus_csum8 u_wr_csum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (csum_clr),
        .add_i   (accept),
        .data_i  (in_data),
        .sum_o   (wr_sum)
    );

`ifdef DISCUS_LOADER_VERIFY_EN
    logic       snoopm_q, snoopm_d;
    logic [8:0] rd_cnt_q, rd_cnt_d;
    logic       rd_add_q;
    logic [7:0] rd_sum;

    discus_csum8 u_rd_csum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (csum_clr),
        .add_i   (rd_add_q),
        .data_i  (snoopq),
        .sum_o   (rd_sum)
    );
`else
    logic snoopq_unused;
    assign snoopq_unused = ^snoopq;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        stop_d   = stop_q;
        abort_d  = abort_q;
        error_d  = error_q;
        snoopp_d = 1'b0;
        snoopa_d = snoopa_q;
        snoopd_d = snoopd_q;
        csum_clr = 1'b0;
`ifdef DISCUS_LOADER_VERIFY_EN
        snoopm_d = snoopm_q;
        rd_cnt_d = rd_cnt_q;
`endif
        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d  = LOAD;
                    count_d  = '0;
                    stop_d   = 1'b0;
                    abort_d  = 1'b0;
                    error_d  = 1'b0;
                    csum_clr = 1'b1;
`ifdef DISCUS_LOADER_VERIFY_EN
                    rd_cnt_d = '0;
`endif
                end
            end
            LOAD: begin
                // stop_q marks the strobe cycle of the final byte; leave once it is out.
                if (stop_q) begin
`ifdef DISCUS_LOADER_VERIFY_EN
                    state_d = abort_q ? IDLE : VERIFY;
`else
                    state_d = abort_q ? IDLE : RUN;
`endif
                end else if (accept) begin
                    snoopp_d = 1'b1;
`ifdef DISCUS_LOADER_VERIFY_EN
                    snoopm_d = SNOOP_WR;
`endif
                    snoopa_d = count_q[7:0];
                    snoopd_d = in_data;
                    count_d  = count_q + 9'd1;
                    if (in_last) begin
                        stop_d = 1'b1;
                    end else if (count_q + 9'd1 == MAX_CNT) begin
                        stop_d  = 1'b1;
                        abort_d = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
`ifdef DISCUS_LOADER_VERIFY_EN
            VERIFY: begin
                // Compare only after the last read strobe's data has been summed.
                if (rd_cnt_q != count_q) begin
                    snoopp_d = 1'b1;
                    snoopm_d = SNOOP_RD;
                    snoopa_d = rd_cnt_q[7:0];
                    rd_cnt_d = rd_cnt_q + 9'd1;
                end else if (!snoopp_q && !rd_add_q) begin
                    if (rd_sum == wr_sum) begin
                        state_d = RUN;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // The CPU is released only on the second consecutive cycle spent in RUN.
        cpu_reset_d = !((state_q == RUN) && (state_d == RUN));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            stop_q      <= 1'b0;
            abort_q     <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            snoopp_q    <= 1'b0;
            snoopa_q    <= '0;
            snoopd_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            stop_q      <= stop_d;
            abort_q     <= abort_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
            snoopp_q    <= snoopp_d;
            snoopa_q    <= snoopa_d;
            snoopd_q    <= snoopd_d;
        end
    end

`ifdef DISCUS_LOADER_VERIFY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snoopm_q <= SNOOP_WR;
            rd_cnt_q <= '0;
            rd_add_q <= 1'b0;
        end else begin
            snoopm_q <= snoopm_d;
            rd_cnt_q <= rd_cnt_d;
            rd_add_q <= snoopp_q && (snoopm_q == SNOOP_RD);
        end
    end

    assign snoopm = snoopm_q;
`else
    assign snoopm = SNOOP_WR;
`endif

    assign cpu_reset = cpu_reset_q || ((state_q == RUN) && start);
    assign snoopp    = snoopp_q;
    assign snoopa    = snoopa_q;
    assign snoopd    = snoopd_q;
    assign busy      = (state_q == LOAD)
`ifdef DISCUS_LOADER_VERIFY_EN
                       || (state_q == VERIFY)
`endif
                       ;
    assign done      = (state_q == RUN);
    assign error     = error_q;
    assign count     = count_q;

endmodule

// File: tb/tb_discus_loader.sv
// Scoreboard bench for discus_loader: stimulus pushes expected snoop strobes, monitors pop and compare.
module tb_discus_loader;
    import discus_pkg::*;

    typedef struct packed {
        logic       rd;
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       start4 = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic [7:0] snoopq = 8'h00;
    logic [7:0] snoopq4 = 8'h00;

    logic       rdy, cpu_rst, sp, sm, busy, done, err;
    logic [7:0] sa, sd;
    logic [8:0] cnt;
    logic       rdy4, cpu_rst4, sp4, sm4, busy4, done4, err4;
    logic [7:0] sa4, sd4;
    logic [8:0] cnt4;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_wr = 0, wr_first = 0, wr_last = 0;
    int   n_wr4 = 0;
    exp_t exp_q[$];
    exp_t exp4_q[$];
    exp_t e, e4;
    bit   corrupt = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] stream [12];

    always #5 clk = ~clk;

    discus_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(rdy),
        .in_data(in_data), .in_last(in_last), .cpu_reset(cpu_rst), .snoopa(sa), .snoopd(sd),
        .snoopp(sp), .snoopm(sm), .snoopq(snoopq), .busy(busy), .done(done), .error(err),
        .count(cnt)
    );

    discus_loader #(.MAX_LEN(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .in_valid(in_valid), .in_ready(rdy4),
        .in_data(in_data), .in_last(in_last), .cpu_reset(cpu_rst4), .snoopa(sa4), .snoopd(sd4),
        .snoopp(sp4), .snoopm(sm4), .snoopq(snoopq4), .busy(busy4), .done(done4), .error(err4),
        .count(cnt4)
    );

    // Program memory behind the snoop port; read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (sp) begin
            if (!sm) mem[sa] <= sd;
            else     snoopq  <= (corrupt && sa == 8'd5) ? 8'h11 : mem[sa];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sp) begin
            if (exp_q.size() == 0) begin
                check("spurious_strobe", sp, 0);
            end else begin
                e = exp_q.pop_front();
                $display("[%0t] strobe %s a=%02h d=%02h", $time, sm ? "rd" : "wr", sa, sd);
                check("strobe_mode", sm, e.rd);
                check("strobe_addr", sa, e.a);
                if (!e.rd) begin
                    check("strobe_data", sd, e.d);
                    if (n_wr == 0) wr_first = cyc;
                    wr_last = cyc;
                    n_wr++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sp4) begin
            if (exp4_q.size() == 0) begin
                check("spurious_strobe4", sp4, 0);
            end else begin
                e4 = exp4_q.pop_front();
                $display("[%0t] strobe4 wr a=%02h d=%02h", $time, sa4, sd4);
                check("strobe4_mode", sm4, 0);
                check("strobe4_addr", sa4, e4.a);
                check("strobe4_data", sd4, e4.d);
                n_wr4++;
            end
        end
    end

    task automatic pulse_start(input bit to4);
        @(negedge clk);
        if (to4) start4 = 1'b1;
        else     start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    // Offers stream[first..first+n-1] at addresses first..; stops early if in_ready stays low.
    task automatic feed(input int first, input int n, input bit with_last, input bit to4,
                        output int accepted);
        int   waitc;
        exp_t x;
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = stream[(first + i) % 12];
            in_last  = with_last && (i == n - 1);
            waitc = 0;
            while (!(to4 ? rdy4 : rdy) && waitc < 4) begin
                @(negedge clk);
                waitc++;
            end
            if (!(to4 ? rdy4 : rdy)) break;
            x.rd = 1'b0;
            x.a  = 8'(first + i);
            x.d  = in_data;
            if (to4) exp4_q.push_back(x);
            else     exp_q.push_back(x);
            accepted++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_reads(input int n);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            x.rd = 1'b1;
            x.a  = 8'(i);
            x.d  = 8'h00;
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_done(input string nm);
        int waitc = 0;
        while (!done && waitc < 80) begin
            @(negedge clk);
            waitc++;
        end
        check(nm, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int waitc;
        stream = '{8'h50, 8'he8, 8'h91, 8'hda, 8'h0b, 8'h10, 8'h43, 8'he8,
                   8'hc9, 8'hc9, 8'hc9, 8'ha8};

        // Reset values
        @(negedge clk);
        check("rst_cpu_reset", cpu_rst, 1);
        check("rst_in_ready", rdy, 0);
        check("rst_snoopp", sp, 0);
        check("rst_busy_done_err", {busy, done, err}, 3'b000);
        check("rst_count", cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full 12-byte load, in_valid held high
        n_wr = 0;
        pulse_start(1'b0);
        check("load_busy", busy, 1);
        feed(0, 12, 1'b1, 1'b0, acc);
`ifdef DISCUS_LOADER_VERIFY_EN
        push_reads(12);
`endif
        wait_done("s1_done");
        check("s1_first_run_cpu_reset", cpu_rst, 1);
        @(negedge clk);
        check("s1_cpu_reset_fell", cpu_rst, 0);
        check("s1_count", cnt, 12);
        check("s1_wr_sum", dut.wr_sum, 8'hec);
        check("s1_error", err, 0);
        check("s1_busy", busy, 0);
        check("s1_write_strobes", n_wr, 12);
        check("s1_back_to_back", wr_last - wr_first + 1, 12);
        check("s1_queue_drained", exp_q.size(), 0);

        // start in RUN restarts at address 0; start in LOAD is ignored
        @(negedge clk);
        start = 1'b1;
        #1;
        check("s6_cpu_reset_same_cycle", cpu_rst, 1);
        @(negedge clk);
        start = 1'b0;
        check("s6_busy", busy, 1);
        check("s6_count_cleared", cnt, 0);
        feed(0, 1, 1'b0, 1'b0, acc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(1, 1, 1'b1, 1'b0, acc);
`ifdef DISCUS_LOADER_VERIFY_EN
        push_reads(2);
`endif
        wait_done("s6_done");
        check("s6_count", cnt, 2);
        check("s6_wr_sum", dut.wr_sum, 8'h38);
        check("s6_queue_drained", exp_q.size(), 0);

`ifdef DISCUS_LOADER_VERIFY_EN
        // Read-back mismatch at address 5
        corrupt = 1'b1;
        pulse_start(1'b0);
        feed(0, 12, 1'b1, 1'b0, acc);
        push_reads(12);
        waitc = 0;
        while (busy && waitc < 80) begin
            @(negedge clk);
            waitc++;
        end
        check("s3_left_verify", busy, 0);
        check("s3_error", err, 1);
        check("s3_done", done, 0);
        check("s3_cpu_reset", cpu_rst, 1);
        check("s3_state_idle", dut.state_q, IDLE);
        check("s3_queue_drained", exp_q.size(), 0);
        corrupt = 1'b0;
`endif

        // Asynchronous reset in the middle of a load
        pulse_start(1'b0);
        feed(0, 3, 1'b0, 1'b0, acc);
        #2;
        reset_n = 1'b0;
        #1;
        check("s5_cpu_reset", cpu_rst, 1);
        check("s5_in_ready", rdy, 0);
        check("s5_snoop", {sp, sm, sa, sd}, 18'h0);
        check("s5_flags", {busy, done, err}, 3'b000);
        check("s5_count", cnt, 0);
        in_valid = 1'b1;
        in_data  = stream[3];
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("s5_idle_after_reset", busy, 0);
        check("s5_queue_drained", exp_q.size(), 0);

        // MAX_LEN=4 overflow without in_last
        pulse_start(1'b1);
        feed(0, 5, 1'b0, 1'b1, acc);
        repeat (2) @(negedge clk);
        check("s4_accepted", acc, 4);
        check("s4_strobes", n_wr4, 4);
        check("s4_error", err4, 1);
        check("s4_in_ready", rdy4, 0);
        check("s4_cpu_reset", cpu_rst4, 1);
        check("s4_count", cnt4, 4);
        check("s4_busy_done", {busy4, done4}, 2'b00);
        check("s4_queue_drained", exp4_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/discus_loader.md
DISCUS_LOADER -- requirements
Module: discus_loader

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256, meaning the highest number of program bytes accepted per load (1..256).
REQ-002 SHALL have port clk  input  1  sole clock; also drives the discus snoop_clk.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle pulse that begins a load.
REQ-005 SHALL have port in_valid / in_ready  input / output  1 / 1  byte-stream handshake.
REQ-006 SHALL have port in_data  input  8  program byte.
REQ-007 SHALL have port in_last  input  1  marks the final byte.
REQ-008 SHALL have port cpu_reset  output  1  active-high reset to discus.
REQ-009 SHALL have port snoopa, snoopd  output  8 each  snoop address and write data.
REQ-010 SHALL have port snoopp, snoopm  output  1 each  snoop strobe and mode (0 write, 1 read).
REQ-011 SHALL have port snoopq  input  8  snoop read data, valid one cycle after a read strobe.
REQ-012 SHALL have port busy, done, error  output  1 each  status flags.
REQ-013 SHALL have port count  output  9  number of bytes written in the last load.

Function
REQ-014 SHALL implement the states IDLE, LOAD, VERIFY and RUN.
REQ-015 IDLE: cpu_reset=1, snoopp=0, in_ready=0; start moves to LOAD and clears count, address, checksum and error.
REQ-016 LOAD: in_ready=1; each in_valid&in_ready byte SHALL, on the next cycle, drive snoopp=1, snoopm=0, snoopa=address and snoopd=byte for exactly one cycle; the address then increments.
REQ-017 Writes SHALL be back-to-back when in_valid is held high: one byte per cycle, latency 1 cycle from accept to strobe.
REQ-018 Each accepted byte SHALL be added to the 8-bit wrap-around write checksum.
REQ-019 When in_last is accepted, the FSM SHALL leave LOAD after that byte's strobe; count equals the number of accepted bytes.
REQ-020 When byte number MAX_LEN is accepted without in_last, error SHALL be set, in_ready deasserted, and the FSM SHALL go to IDLE with cpu_reset held at 1.
REQ-021 RUN: snoopp=0; cpu_reset SHALL fall one cycle after RUN is entered; done=1.
REQ-022 start in RUN SHALL reassert cpu_reset in the same cycle and enter LOAD.
REQ-023 start in LOAD or VERIFY SHALL be ignored.
REQ-024 busy=1 in LOAD and VERIFY only.
REQ-025 in_valid without in_ready SHALL have no effect.

Reset
REQ-026 Asserting reset_n low SHALL force IDLE immediately, regardless of the current state or any load in progress.
REQ-027 Reset values: cpu_reset=1, in_ready=0, snoopp=0, snoopm=0, snoopa=0, snoopd=0, busy=0, done=0, error=0, count=0.

Configuration
REQ-028 SHALL have macro DISCUS_LOADER_VERIFY_EN.
REQ-029 When DISCUS_LOADER_VERIFY_EN is defined, LOAD SHALL exit to VERIFY. VERIFY issues one read strobe per cycle (snoopp=1, snoopm=1) for addresses 0..count-1 and sums snoopq, sampled one cycle after each strobe, into an 8-bit read checksum. A match goes to RUN; a mismatch sets error and goes to IDLE.
REQ-030 When DISCUS_LOADER_VERIFY_EN is undefined, LOAD SHALL exit directly to RUN, snoopm SHALL be constant 0, and the VERIFY state SHALL not exist.

Structure
REQ-031 The state encoding and snoop mode constants SNOOP_WR=0 and SNOOP_RD=1 SHALL live in the shared package discus_pkg.
REQ-032 The checksum accumulator SHALL be the sub-module discus_csum8 (clear, add-enable, 8-bit data, 8-bit sum), instantiated once for write and once for read.

Verification
REQ-033 Scenario: stream 50 e8 91 da 0b 10 43 e8 c9 c9 c9 a8, with in_last on a8 and in_valid held high -> 12 consecutive write strobes at addresses 0..11, count=12, write checksum 0xec, then cpu_reset falls and done=1.
REQ-034 Scenario: same stream with DISCUS_LOADER_VERIFY_EN and a memory model that returns the written data -> 12 read strobes at addresses 0..11, error=0, then RUN.
REQ-035 Scenario: same stream with the model corrupting address 5 to 0x11 -> error=1, FSM back in IDLE, cpu_reset still 1.
REQ-036 Scenario: MAX_LEN=4, stream 5 bytes with no in_last -> 4 write strobes, error=1, in_ready=0 afterwards.
REQ-037 Scenario: reset_n pulsed low after byte 3 of a load -> all outputs at reset values in the same cycle, and no further strobes.
REQ-038 Scenario: start pulsed in RUN -> cpu_reset=1 in the same cycle, busy=1, and the next accepted byte is written at address 0.
